// File: rtl/tm_ll_qmgr.sv
// tm_ll_qmgr: linked-list queue manager over a shared buffer pool with alpha-scaled admission
module tm_ll_qmgr #(
  parameter int NUM_Q = 64,
  parameter int NUM_BUF = 256,
  parameter int DESC_W = 64,
  localparam int QID_W = $clog2(NUM_Q),
  localparam int BID_W = $clog2(NUM_BUF),
  localparam int CNT_W = BID_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        alpha,
  input  logic              enq_req,
  input  logic [QID_W-1:0]  enq_qid,
  input  logic [DESC_W-1:0] enq_desc,
  output logic              enq_rdy,
  output logic              enq_ack,
  output logic              enq_drop,
  output logic [QID_W-1:0]  enq_ack_qid,
  output logic              enq_to_empty,
  input  logic              deq_req,
  input  logic [QID_W-1:0]  deq_qid,
  output logic              deq_rdy,
  output logic              deq_ack,
  output logic              deq_empty,
  output logic [QID_W-1:0]  deq_ack_qid,
  output logic [DESC_W-1:0] deq_desc,
  output logic              deq_last,
  output logic [CNT_W-1:0]  free_count,
  output logic              init_done
);
  localparam int MAXN = NUM_BUF > NUM_Q ? NUM_BUF : NUM_Q;
  localparam int IW = $clog2(MAXN) + 1;
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] free_count_q, free_count_d;
  logic [BID_W-1:0] fl_rd_q, fl_rd_d, fl_wr_q, fl_wr_d;
  logic s1_v_q, s1_v_d, s1_deq_q, s1_deq_d;
  logic [QID_W-1:0] s1_qid_q, s1_qid_d;
  logic [DESC_W-1:0] s1_desc_q, s1_desc_d;
  logic enq_ack_q, enq_ack_d, enq_drop_q, enq_drop_d, enq_to_empty_q, enq_to_empty_d;
  logic deq_ack_q, deq_ack_d, deq_empty_q, deq_empty_d, deq_last_q, deq_last_d;
  logic [QID_W-1:0] enq_ack_qid_q, enq_ack_qid_d, deq_ack_qid_q, deq_ack_qid_d;
  logic [DESC_W-1:0] deq_desc_q, deq_desc_d;
  logic [BID_W-1:0] head_mem [NUM_Q];
  logic [BID_W-1:0] tail_mem [NUM_Q];
  logic [CNT_W-1:0] depth_mem [NUM_Q];
  logic [BID_W-1:0] nxt_mem [NUM_BUF];
  logic [BID_W-1:0] fl_mem [NUM_BUF];
  logic [DESC_W-1:0] desc_mem [NUM_BUF];
  logic [CNT_W-1:0] dep;
  logic [BID_W-1:0] hd, bid;
  logic [CNT_W+6:0] thr;
  logic deq_acc, enq_acc, drop, go, do_enq, do_deq, init_fl, init_dp;
  assign init_done = state_q == RUN;
  assign deq_rdy = init_done & ~(s1_v_q & (s1_qid_q == deq_qid));
  assign enq_rdy = init_done & ~(deq_req & deq_rdy) & ~(s1_v_q & (s1_qid_q == enq_qid));
  assign deq_acc = deq_req & deq_rdy;
  assign enq_acc = enq_req & enq_rdy;
  assign dep = depth_mem[s1_qid_q];
  assign hd = head_mem[s1_qid_q];
  assign bid = fl_mem[fl_rd_q];
  assign thr = alpha[3] ? {7'd0, free_count_q} >> alpha[2:0] : {7'd0, free_count_q} << alpha[2:0];
  assign drop = free_count_q == '0 || {7'd0, dep} >= thr;
  assign go = s1_v_q & ~rst;
  assign do_enq = go & ~s1_deq_q & ~drop;
  assign do_deq = go & s1_deq_q & (dep != '0);
  assign init_fl = state_q == INIT && cnt_q < IW'(NUM_BUF);
  assign init_dp = state_q == INIT && cnt_q < IW'(NUM_Q);
  assign free_count = free_count_q;
  assign enq_ack = enq_ack_q;
  assign enq_drop = enq_drop_q;
  assign enq_ack_qid = enq_ack_qid_q;
  assign enq_to_empty = enq_to_empty_q;
  assign deq_ack = deq_ack_q;
  assign deq_empty = deq_empty_q;
  assign deq_ack_qid = deq_ack_qid_q;
  assign deq_desc = deq_desc_q;
  assign deq_last = deq_last_q;
  always_comb begin
    state_d = (state_q == INIT && cnt_q == IW'(MAXN - 1)) ? RUN : state_q;
    cnt_d = state_q == INIT ? cnt_q + IW'(1) : cnt_q;
    fl_wr_d = fl_wr_q + BID_W'(init_fl | do_deq);
    fl_rd_d = fl_rd_q + BID_W'(do_enq);
    free_count_d = free_count_q + CNT_W'(init_fl | do_deq) - CNT_W'(do_enq);
    s1_v_d = deq_acc | enq_acc;
    s1_deq_d = deq_acc;
    s1_qid_d = deq_acc ? deq_qid : enq_qid;
    s1_desc_d = enq_desc;
    enq_ack_d = s1_v_q & ~s1_deq_q;
    enq_drop_d = enq_ack_d & drop;
    enq_to_empty_d = do_enq & (dep == '0);
    enq_ack_qid_d = enq_ack_d ? s1_qid_q : enq_ack_qid_q;
    deq_ack_d = s1_v_q & s1_deq_q;
    deq_empty_d = deq_ack_d & (dep == '0);
    deq_last_d = do_deq & (dep == CNT_W'(1));
    deq_ack_qid_d = deq_ack_d ? s1_qid_q : deq_ack_qid_q;
    deq_desc_d = do_deq ? desc_mem[hd] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q <= '0;
      free_count_q <= '0;
      fl_rd_q <= '0;
      fl_wr_q <= '0;
      s1_v_q <= 1'b0;
      s1_deq_q <= 1'b0;
      s1_qid_q <= '0;
      s1_desc_q <= '0;
      enq_ack_q <= 1'b0;
      enq_drop_q <= 1'b0;
      enq_to_empty_q <= 1'b0;
      enq_ack_qid_q <= '0;
      deq_ack_q <= 1'b0;
      deq_empty_q <= 1'b0;
      deq_last_q <= 1'b0;
      deq_ack_qid_q <= '0;
      deq_desc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      free_count_q <= free_count_d;
      fl_rd_q <= fl_rd_d;
      fl_wr_q <= fl_wr_d;
      s1_v_q <= s1_v_d;
      s1_deq_q <= s1_deq_d;
      s1_qid_q <= s1_qid_d;
      s1_desc_q <= s1_desc_d;
      enq_ack_q <= enq_ack_d;
      enq_drop_q <= enq_drop_d;
      enq_to_empty_q <= enq_to_empty_d;
      enq_ack_qid_q <= enq_ack_qid_d;
      deq_ack_q <= deq_ack_d;
      deq_empty_q <= deq_empty_d;
      deq_last_q <= deq_last_d;
      deq_ack_qid_q <= deq_ack_qid_d;
      deq_desc_q <= deq_desc_d;
    end
  end
  always_ff @(posedge clk) begin
    if (init_fl) fl_mem[cnt_q[BID_W-1:0]] <= cnt_q[BID_W-1:0];
    if (init_dp) depth_mem[cnt_q[QID_W-1:0]] <= '0;
    if (do_deq) begin
      fl_mem[fl_wr_q] <= hd;
      head_mem[s1_qid_q] <= nxt_mem[hd];
      depth_mem[s1_qid_q] <= dep - CNT_W'(1);
    end
    if (do_enq) begin
      desc_mem[bid] <= s1_desc_q;
      tail_mem[s1_qid_q] <= bid;
      depth_mem[s1_qid_q] <= dep + CNT_W'(1);
      if (dep == '0) head_mem[s1_qid_q] <= bid;
      else nxt_mem[tail_mem[s1_qid_q]] <= bid;
    end
  end
  always_ff @(posedge clk) begin
    if (do_enq) assert (dep < CNT_W'(NUM_BUF) && free_count_q != '0);
  end
endmodule

// File: tb/tb_tm_ll_qmgr.sv
// tb_tm_ll_qmgr: directed checks of init, FIFO order, threshold, hazards, pool exhaustion and reset
module tb_tm_ll_qmgr;
  logic clk = 1'b0;
  logic rst, sel;
  logic [3:0] alpha;
  logic enq_req, deq_req;
  logic [5:0] enq_qid, deq_qid;
  logic [63:0] enq_desc;
  logic a_enq_rdy, a_enq_ack, a_enq_drop, a_enq_to_empty, a_deq_rdy, a_deq_ack, a_deq_empty, a_deq_last, a_init_done;
  logic b_enq_rdy, b_enq_ack, b_enq_drop, b_enq_to_empty, b_deq_rdy, b_deq_ack, b_deq_empty, b_deq_last, b_init_done;
  logic [5:0] a_enq_ack_qid, a_deq_ack_qid, b_enq_ack_qid, b_deq_ack_qid;
  logic [63:0] a_deq_desc, b_deq_desc;
  logic [8:0] a_free_count;
  logic [2:0] b_free_count;
  logic o_enq_rdy, o_enq_ack, o_enq_drop, o_enq_to_empty, o_deq_rdy, o_deq_ack, o_deq_empty, o_deq_last;
  logic [5:0] o_enq_ack_qid, o_deq_ack_qid;
  logic [63:0] o_deq_desc;
  logic [8:0] o_free;
  logic r_ack, r_drop, r_te, r_empty, r_last;
  logic [5:0] r_qid;
  logic [63:0] r_desc;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  tm_ll_qmgr u_a (
    .clk(clk), .rst(rst), .alpha(alpha),
    .enq_req(enq_req), .enq_qid(enq_qid), .enq_desc(enq_desc), .enq_rdy(a_enq_rdy),
    .enq_ack(a_enq_ack), .enq_drop(a_enq_drop), .enq_ack_qid(a_enq_ack_qid), .enq_to_empty(a_enq_to_empty),
    .deq_req(deq_req), .deq_qid(deq_qid), .deq_rdy(a_deq_rdy),
    .deq_ack(a_deq_ack), .deq_empty(a_deq_empty), .deq_ack_qid(a_deq_ack_qid), .deq_desc(a_deq_desc),
    .deq_last(a_deq_last), .free_count(a_free_count), .init_done(a_init_done)
  );
  tm_ll_qmgr #(.NUM_Q(64), .NUM_BUF(4), .DESC_W(64)) u_b (
    .clk(clk), .rst(rst), .alpha(alpha),
    .enq_req(enq_req), .enq_qid(enq_qid), .enq_desc(enq_desc), .enq_rdy(b_enq_rdy),
    .enq_ack(b_enq_ack), .enq_drop(b_enq_drop), .enq_ack_qid(b_enq_ack_qid), .enq_to_empty(b_enq_to_empty),
    .deq_req(deq_req), .deq_qid(deq_qid), .deq_rdy(b_deq_rdy),
    .deq_ack(b_deq_ack), .deq_empty(b_deq_empty), .deq_ack_qid(b_deq_ack_qid), .deq_desc(b_deq_desc),
    .deq_last(b_deq_last), .free_count(b_free_count), .init_done(b_init_done)
  );
  assign o_enq_rdy = sel ? b_enq_rdy : a_enq_rdy;
  assign o_enq_ack = sel ? b_enq_ack : a_enq_ack;
  assign o_enq_drop = sel ? b_enq_drop : a_enq_drop;
  assign o_enq_to_empty = sel ? b_enq_to_empty : a_enq_to_empty;
  assign o_enq_ack_qid = sel ? b_enq_ack_qid : a_enq_ack_qid;
  assign o_deq_rdy = sel ? b_deq_rdy : a_deq_rdy;
  assign o_deq_ack = sel ? b_deq_ack : a_deq_ack;
  assign o_deq_empty = sel ? b_deq_empty : a_deq_empty;
  assign o_deq_last = sel ? b_deq_last : a_deq_last;
  assign o_deq_ack_qid = sel ? b_deq_ack_qid : a_deq_ack_qid;
  assign o_deq_desc = sel ? b_deq_desc : a_deq_desc;
  assign o_free = sel ? {6'd0, b_free_count} : a_free_count;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic dq, input logic [5:0] q, input logic [63:0] d);
    int n;
    n = 0;
    @(negedge clk);
    if (dq) begin
      deq_req = 1'b1;
      deq_qid = q;
    end else begin
      enq_req = 1'b1;
      enq_qid = q;
      enq_desc = d;
    end
    #1;
    while (!(dq ? o_deq_rdy : o_enq_rdy) && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("op_rdy", 64'(dq ? o_deq_rdy : o_enq_rdy), 64'd1);
    @(negedge clk);
    enq_req = 1'b0;
    deq_req = 1'b0;
    @(negedge clk);
    #1;
    r_ack = dq ? o_deq_ack : o_enq_ack;
    r_drop = o_enq_drop;
    r_te = o_enq_to_empty;
    r_empty = o_deq_empty;
    r_last = o_deq_last;
    r_qid = dq ? o_deq_ack_qid : o_enq_ack_qid;
    r_desc = o_deq_desc;
  endtask
  task automatic wait_init(output int na, output int nb);
    int n;
    n = 0;
    na = 0;
    nb = 0;
    while ((!a_init_done || !b_init_done) && n < 400) begin
      @(negedge clk);
      n++;
      if (a_init_done && na == 0) na = n;
      if (b_init_done && nb == 0) nb = n;
      if (n == 10) begin
        enq_req = 1'b1;
        enq_qid = 6'd0;
        deq_req = 1'b1;
        deq_qid = 6'd0;
        #1;
        chk("init_enq_rdy", 64'(a_enq_rdy), 64'd0);
        chk("init_deq_rdy", 64'(a_deq_rdy), 64'd0);
      end
      if (n == 11) begin
        enq_req = 1'b0;
        deq_req = 1'b0;
      end
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int na, nb, adm;
    sel = 1'b0;
    rst = 1'b1;
    alpha = 4'b0000;
    enq_req = 1'b0;
    deq_req = 1'b0;
    enq_qid = '0;
    deq_qid = '0;
    enq_desc = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_init_done", 64'(a_init_done), 64'd0);
    chk("rst_free", 64'(a_free_count), 64'd0);
    chk("rst_enq_ack", 64'(a_enq_ack), 64'd0);
    chk("rst_deq_ack", 64'(a_deq_ack), 64'd0);
    chk("rst_deq_desc", a_deq_desc, 64'd0);
    chk("rst_enq_rdy", 64'(a_enq_rdy), 64'd0);
    rst = 1'b0;
    wait_init(na, nb);
    chk("init_cycles_256", 64'(na), 64'd256);
    chk("init_cycles_small", 64'(nb), 64'd64);
    chk("init_free_256", 64'(a_free_count), 64'd256);
    chk("init_free_small", 64'(b_free_count), 64'd4);
    op(1'b0, 6'd5, 64'hA);
    chk("fifo_ack", 64'(r_ack), 64'd1);
    chk("fifo_to_empty", 64'(r_te), 64'd1);
    chk("fifo_drop", 64'(r_drop), 64'd0);
    chk("fifo_ack_qid", 64'(r_qid), 64'd5);
    op(1'b0, 6'd5, 64'hB);
    chk("fifo_to_empty2", 64'(r_te), 64'd0);
    op(1'b0, 6'd5, 64'hC);
    chk("fifo_free_253", 64'(o_free), 64'd253);
    op(1'b1, 6'd5, 64'd0);
    chk("fifo_deq_a", r_desc, 64'hA);
    chk("fifo_last_a", 64'(r_last), 64'd0);
    chk("fifo_deq_qid", 64'(r_qid), 64'd5);
    op(1'b1, 6'd5, 64'd0);
    chk("fifo_deq_b", r_desc, 64'hB);
    op(1'b1, 6'd5, 64'd0);
    chk("fifo_deq_c", r_desc, 64'hC);
    chk("fifo_last_c", 64'(r_last), 64'd1);
    op(1'b1, 6'd5, 64'd0);
    chk("fifo_empty_ack", 64'(r_ack), 64'd1);
    chk("fifo_empty", 64'(r_empty), 64'd1);
    chk("fifo_empty_desc", r_desc, 64'd0);
    chk("fifo_free_256", 64'(o_free), 64'd256);
    // thr = free_count>>3 shrinks as the queue grows: depth k is admitted while k < (256-k)>>3, so 28 fit
    alpha = 4'b1011;
    adm = 0;
    for (int i = 0; i < 33; i++) begin
      op(1'b0, 6'd1, 64'h100 + 64'(i));
      if (!r_drop) adm++;
      if (i == 27) chk("thr_28th_admit", 64'(r_drop), 64'd0);
      if (i == 28) begin
        chk("thr_29th_drop", 64'(r_drop), 64'd1);
        chk("thr_drop_ack", 64'(r_ack), 64'd1);
      end
    end
    chk("thr_admitted", 64'(adm), 64'd28);
    chk("thr_free", 64'(o_free), 64'd228);
    op(1'b1, 6'd1, 64'd0);
    chk("thr_head", r_desc, 64'h100);
    alpha = 4'b0000;
    @(negedge clk);
    deq_req = 1'b1;
    deq_qid = 6'd2;
    enq_req = 1'b1;
    enq_qid = 6'd3;
    enq_desc = 64'h33;
    #1;
    chk("pri_deq_rdy", 64'(o_deq_rdy), 64'd1);
    chk("pri_enq_rdy", 64'(o_enq_rdy), 64'd0);
    @(negedge clk);
    deq_req = 1'b0;
    #1;
    chk("pri_enq_rdy_next", 64'(o_enq_rdy), 64'd1);
    @(negedge clk);
    enq_req = 1'b0;
    deq_req = 1'b1;
    deq_qid = 6'd3;
    #1;
    chk("pri_deq_ack", 64'(o_deq_ack), 64'd1);
    chk("pri_deq_empty", 64'(o_deq_empty), 64'd1);
    chk("pri_deq_qid", 64'(o_deq_ack_qid), 64'd2);
    chk("haz_deq_stall", 64'(o_deq_rdy), 64'd0);
    @(negedge clk);
    #1;
    chk("haz_enq_ack", 64'(o_enq_ack), 64'd1);
    chk("haz_enq_to_empty", 64'(o_enq_to_empty), 64'd1);
    chk("haz_deq_rdy", 64'(o_deq_rdy), 64'd1);
    @(negedge clk);
    deq_req = 1'b0;
    @(negedge clk);
    #1;
    chk("haz_deq_ack", 64'(o_deq_ack), 64'd1);
    chk("haz_deq_desc", o_deq_desc, 64'h33);
    chk("haz_deq_last", 64'(o_deq_last), 64'd1);
    sel = 1'b1;
    alpha = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      op(1'b0, 6'(i), 64'h10 + 64'(i));
      chk("pool_admit", 64'(r_drop), 64'd0);
    end
    op(1'b0, 6'd0, 64'h14);
    chk("pool_5th_drop", 64'(r_drop), 64'd1);
    chk("pool_free_0", 64'(o_free), 64'd0);
    @(negedge clk);
    deq_req = 1'b1;
    deq_qid = 6'd0;
    #1;
    chk("pool_deq_rdy", 64'(o_deq_rdy), 64'd1);
    @(negedge clk);
    deq_req = 1'b0;
    enq_req = 1'b1;
    enq_qid = 6'd0;
    enq_desc = 64'h15;
    #1;
    chk("pool_enq_stall", 64'(o_enq_rdy), 64'd0);
    @(negedge clk);
    #1;
    chk("pool_deq_desc", o_deq_desc, 64'h10);
    chk("pool_enq_rdy", 64'(o_enq_rdy), 64'd1);
    @(negedge clk);
    enq_req = 1'b0;
    @(negedge clk);
    #1;
    chk("pool_reuse_ack", 64'(o_enq_ack), 64'd1);
    chk("pool_reuse_drop", 64'(o_enq_drop), 64'd0);
    chk("pool_reuse_free", 64'(o_free), 64'd0);
    op(1'b1, 6'd0, 64'd0);
    chk("pool_reuse_desc", r_desc, 64'h15);
    sel = 1'b0;
    @(negedge clk);
    enq_req = 1'b1;
    enq_qid = 6'd7;
    enq_desc = 64'h77;
    #1;
    chk("rmid_enq_rdy", 64'(o_enq_rdy), 64'd1);
    @(negedge clk);
    enq_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rmid_no_ack", 64'(o_enq_ack), 64'd0);
    chk("rmid_init_done", 64'(a_init_done), 64'd0);
    @(negedge clk);
    #1;
    chk("rmid_no_ack_late", 64'(o_enq_ack), 64'd0);
    wait_init(na, nb);
    chk("rmid_init_free", 64'(a_free_count), 64'd256);
    op(1'b1, 6'd7, 64'd0);
    chk("rmid_q7_empty", 64'(r_empty), 64'd1);
    op(1'b1, 6'd1, 64'd0);
    chk("rmid_q1_empty", 64'(r_empty), 64'd1);
    op(1'b1, 6'd3, 64'd0);
    chk("rmid_q3_empty", 64'(r_empty), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
